goertzel_axi_regs: RTL
======================

Name: goertzel_axi_regs

Overview:
- AXI-Lite slave register bank that sits directly downstream of the AXI interconnect. It consumes the axi_lite_mosi struct and produces the axi_lite_miso struct from axi_pkg.
- Exposes control, configuration, status and result registers of the Goertzel core to software.
- Drives core config/control signals and captures the core's status and result.

Parameters:
- ADDR_W, 8: decoded address bits; word offset is awaddr/araddr[ADDR_W-1:2]; bits [1:0] ignored; bits above ADDR_W ignored.
- NSAMP_RST, 16'd205: reset value of NSAMP.
- COEFF_RST, 32'h0: reset value of COEFF.

Ports:
- clk  input  1  single clock for all logic
- rst  input  1  synchronous reset, active-high
- s_axi_mosi  input  axi_lite_mosi  AXI-Lite request channels (AW, W, B-ready, AR, R-ready)
- s_axi_miso  output  axi_lite_miso  AXI-Lite response channels
- start_o  output  1  one-cycle start pulse to the core
- soft_rst_o  output  1  one-cycle core soft-reset pulse
- coeff_o  output  32  Goertzel coefficient (COEFF register)
- nsamp_o  output  16  samples per block (NSAMP register)
- busy_i  input  1  core busy level
- done_i  input  1  one-cycle pulse when a result is valid
- result_i  input  32  core result, valid while done_i=1

Behaviour:
- Register map (byte offset):
  - 0x00 CTRL, write-only, reads 0. bit0 START (write 1: pulse start_o). bit1 SOFT_RST (write 1: pulse soft_rst_o).
  - 0x04 STATUS. bit0 BUSY (RO, live busy_i). bit1 DONE (sticky; set by done_i; W1C).
  - 0x08 COEFF, RW 32-bit, byte strobes honoured.
  - 0x0C NSAMP, RW, bits[15:0] used, bits[31:16] read 0, strobes honoured.
  - 0x10 RESULT, RO, loaded from result_i when done_i=1.
  - Other offsets: writes ignored; reads return 0.
- Response codes:
  - Mapped offsets: bresp/rresp = 2'b00 OKAY.
  - Unmapped offsets: 2'b10 SLVERR.
  - Writes to RO fields: ignored, OKAY.
- Reset values:
  - awready=1, wready=1, arready=1; bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - start_o=0, soft_rst_o=0; COEFF=COEFF_RST, NSAMP=NSAMP_RST, DONE=0, RESULT=0.
  - Both holding registers empty.
- Write path:
  - AW and W are accepted independently.
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - A handshake loads the address or data+strobe into its holding register.
  - Commit happens on the edge ending the first cycle in which both are available: held, or handshaking in that cycle. AW and W in the same cycle T commit at the end of T.
  - At the commit edge: register updated, bvalid=1, holding registers cleared.
  - bvalid stays 1 until bready=1; it drops on the edge of that cycle.
  - No new AW/W is accepted while bvalid=1, so at most one write is outstanding.
  - start_o/soft_rst_o are high for exactly the one cycle after commit. Writing 1 to both bits asserts both in that cycle.
- Read path:
  - arready = !rvalid.
  - On AR handshake in cycle T: rdata/rresp are registered and rvalid=1 from T+1.
  - rdata is held stable until rready=1, then rvalid drops on the edge of that cycle.
  - Next AR is accepted no earlier than the cycle after rvalid drops (no back-to-back without bubble).
- Channel independence: read and write proceed concurrently. A read and a write to the same register in the same cycle return the pre-write value.
- DONE conflicts:
  - done_i=1 in the same cycle as a W1C commit on DONE: set wins, DONE=1.
  - done_i=1 while DONE already 1: RESULT is overwritten; DONE stays 1.
- soft_rst_o does not alter any register in this block.
- Reset mid-transaction: bvalid/rvalid drop at the reset edge, holding registers are cleared, pending commit is discarded, all registers take reset values.

Test Plan:
- Reset, then read 0x0C and 0x08 -> rvalid one cycle after AR handshake; rdata=32'h000000CD then 32'h0; rresp=OKAY.
- AW 0x08 and W 32'hDEADBEEF strb 4'b0101 in same cycle, then read back -> bvalid next cycle, OKAY; read returns 32'h00AD00EF.
- W first with data 32'h1, AW 0x00 three cycles later, bready held low 4 cycles -> awready/wready low while bvalid high; start_o high exactly one cycle after commit; bvalid holds until bready.
- done_i pulse with result_i=32'h12345678, read 0x04 and 0x10, then write 0x04 data 32'h2 -> STATUS bit1=1, RESULT=32'h12345678; after W1C STATUS bit1=0. Repeat with done_i coincident with the W1C commit -> DONE=1.
- Write 0x20 and read 0x3C -> bresp=2'b10, rresp=2'b10, rdata=0; COEFF/NSAMP unchanged.
- Assert rst while bvalid=1 and rvalid=1 with rready=0 -> both low next cycle; COEFF back to COEFF_RST; no start_o pulse.

Source files
------------

// File: rtl/goertzel_axi_regs.sv
// AXI-Lite register bank for the Goertzel core: control pulses, config, sticky status, result.
// Reads answer one cycle after AR; writes commit once both AW and W are available, one write in flight.
package axi_pkg;
   typedef struct packed {
      logic [31:0] awaddr;
      logic        awvalid;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        wvalid;
      logic        bready;
      logic [31:0] araddr;
      logic        arvalid;
      logic        rready;
   } axi_lite_mosi;

   typedef struct packed {
      logic        awready;
      logic        wready;
      logic [1:0]  bresp;
      logic        bvalid;
      logic        arready;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic        rvalid;
   } axi_lite_miso;
endpackage

module goertzel_axi_regs #(
   parameter int          ADDR_W    = 8,
   parameter logic [15:0] NSAMP_RST = 16'd205,
   parameter logic [31:0] COEFF_RST = 32'h0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  axi_pkg::axi_lite_mosi s_axi_mosi,
   output axi_pkg::axi_lite_miso s_axi_miso,
   output logic                 start_o,
   output logic                 soft_rst_o,
   output logic [31:0]          coeff_o,
   output logic [15:0]          nsamp_o,
   input  logic                 busy_i,
   input  logic                 done_i,
   input  logic [31:0]          result_i
);
   localparam int IDX_W = ADDR_W - 2;
   localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_COEFF  = IDX_W'(2);
   localparam logic [IDX_W-1:0] IDX_NSAMP  = IDX_W'(3);
   localparam logic [IDX_W-1:0] IDX_RESULT = IDX_W'(4);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return res;
   endfunction

   logic             aw_held_q, aw_held_d;
   logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
   logic             w_held_q, w_held_d;
   logic [31:0]      w_dat_q, w_dat_d;
   logic [3:0]       w_strb_q, w_strb_d;
   logic             bvalid_q, bvalid_d;
   logic [1:0]       bresp_q, bresp_d;
   logic             rvalid_q, rvalid_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [1:0]       rresp_q, rresp_d;
   logic             start_q, start_d;
   logic             soft_rst_q, soft_rst_d;
   logic [31:0]      coeff_q, coeff_d;
   logic [15:0]      nsamp_q, nsamp_d;
   logic             done_q, done_d;
   logic [31:0]      result_q, result_d;

   logic             aw_rdy, w_rdy, ar_rdy, aw_hs, w_hs, ar_hs, commit;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic [31:0]      wr_dat, nsamp_wr;
   logic [3:0]       wr_strb;
   logic             unused_bits;

   assign unused_bits = &{1'b0, s_axi_mosi.awaddr[31:ADDR_W], s_axi_mosi.awaddr[1:0],
                          s_axi_mosi.araddr[31:ADDR_W], s_axi_mosi.araddr[1:0]};

   always_comb begin
      aw_held_d  = aw_held_q;
      aw_idx_d   = aw_idx_q;
      w_held_d   = w_held_q;
      w_dat_d    = w_dat_q;
      w_strb_d   = w_strb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      start_d    = 1'b0;
      soft_rst_d = 1'b0;
      coeff_d    = coeff_q;
      nsamp_d    = nsamp_q;
      done_d     = done_q;
      result_d   = result_q;

      aw_rdy = !aw_held_q && !bvalid_q;
      w_rdy  = !w_held_q && !bvalid_q;
      ar_rdy = !rvalid_q;
      aw_hs  = s_axi_mosi.awvalid && aw_rdy;
      w_hs   = s_axi_mosi.wvalid && w_rdy;
      ar_hs  = s_axi_mosi.arvalid && ar_rdy;

      // Held values take priority; otherwise use what is handshaking this cycle.
      wr_idx   = aw_held_q ? aw_idx_q : s_axi_mosi.awaddr[ADDR_W-1:2];
      wr_dat   = w_held_q ? w_dat_q : s_axi_mosi.wdata;
      wr_strb  = w_held_q ? w_strb_q : s_axi_mosi.wstrb;
      commit   = (aw_held_q || aw_hs) && (w_held_q || w_hs);
      nsamp_wr = strb_merge({16'h0, nsamp_q}, wr_dat, wr_strb);

      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_idx_d  = s_axi_mosi.awaddr[ADDR_W-1:2];
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         w_dat_d  = s_axi_mosi.wdata;
         w_strb_d = s_axi_mosi.wstrb;
      end
      if (bvalid_q && s_axi_mosi.bready) bvalid_d = 1'b0;

      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = RESP_OKAY;
         case (wr_idx)
            IDX_CTRL: begin
               start_d    = wr_strb[0] && wr_dat[0];
               soft_rst_d = wr_strb[0] && wr_dat[1];
            end
            IDX_STATUS: if (wr_strb[0] && wr_dat[1]) done_d = 1'b0;
            IDX_COEFF:  coeff_d = strb_merge(coeff_q, wr_dat, wr_strb);
            IDX_NSAMP:  nsamp_d = nsamp_wr[15:0];
            IDX_RESULT: ;
            default:    bresp_d = RESP_SLVERR;
         endcase
      end

      // A new result beats a same-cycle W1C so no completion is lost.
      if (done_i) begin
         done_d   = 1'b1;
         result_d = result_i;
      end

      rd_idx = s_axi_mosi.araddr[ADDR_W-1:2];
      if (rvalid_q && s_axi_mosi.rready) rvalid_d = 1'b0;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rresp_d  = RESP_OKAY;
         case (rd_idx)
            IDX_CTRL:   rdata_d = 32'h0;
            IDX_STATUS: rdata_d = {30'h0, done_q, busy_i};
            IDX_COEFF:  rdata_d = coeff_q;
            IDX_NSAMP:  rdata_d = {16'h0, nsamp_q};
            IDX_RESULT: rdata_d = result_q;
            default: begin
               rdata_d = 32'h0;
               rresp_d = RESP_SLVERR;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held_q  <= 1'b0;
         aw_idx_q   <= '0;
         w_held_q   <= 1'b0;
         w_dat_q    <= 32'h0;
         w_strb_q   <= 4'h0;
         bvalid_q   <= 1'b0;
         bresp_q    <= 2'b00;
         rvalid_q   <= 1'b0;
         rdata_q    <= 32'h0;
         rresp_q    <= 2'b00;
         start_q    <= 1'b0;
         soft_rst_q <= 1'b0;
         coeff_q    <= COEFF_RST;
         nsamp_q    <= NSAMP_RST;
         done_q     <= 1'b0;
         result_q   <= 32'h0;
      end else begin
         aw_held_q  <= aw_held_d;
         aw_idx_q   <= aw_idx_d;
         w_held_q   <= w_held_d;
         w_dat_q    <= w_dat_d;
         w_strb_q   <= w_strb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         start_q    <= start_d;
         soft_rst_q <= soft_rst_d;
         coeff_q    <= coeff_d;
         nsamp_q    <= nsamp_d;
         done_q     <= done_d;
         result_q   <= result_d;
      end
   end

   always_comb begin
      s_axi_miso.awready = aw_rdy;
      s_axi_miso.wready  = w_rdy;
      s_axi_miso.bvalid  = bvalid_q;
      s_axi_miso.bresp   = bresp_q;
      s_axi_miso.arready = ar_rdy;
      s_axi_miso.rvalid  = rvalid_q;
      s_axi_miso.rdata   = rdata_q;
      s_axi_miso.rresp   = rresp_q;
   end

   assign start_o    = start_q;
   assign soft_rst_o = soft_rst_q;
   assign coeff_o    = coeff_q;
   assign nsamp_o    = nsamp_q;
endmodule
